// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and widths for the skid stage.
// Occupancy of the stage equals the state encoding.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: payload register with load enable.
// Synchronous active-high reset to RESET_VAL.
module pipe_data_reg #(
    parameter int                DATA_W    = 20,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    // Capture d_i when loaded, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry elastic stage (main + skid register).
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 20,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    state_e            state_q;
    state_e            state_d;
    logic              in_ready_q;
    logic              in_fire;
    logic              out_fire;
    logic              main_ld;
    logic              skid_ld;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign in_fire  = in_valid & in_ready_q & ~flush;
    assign out_fire = out_valid & out_ready;

    // Next state and register load enables; flush squashes without
    // touching the data registers, while a same-cycle out_fire still counts.
    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_data;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ld = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        skid_ld = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ld = 1'b1;
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and registered ready; ready looks ahead at the next state
    // so there is no combinational path from out_ready to in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    pipe_data_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load_i (main_ld),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_data_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_ld),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

`ifdef PIPE_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    // Count cycles where upstream is blocked; saturate at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready_q && !flush && !(&stall_q)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    // Only reset clears the counter; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed + random checks against a queue model.
// Define PIPE_STALL_CNT_EN to also exercise the stall counter.
module tb_pipe_skid_stage;

    localparam int          DW = 20;
    localparam logic [19:0] RV = 20'h0ABCD;
    localparam int          CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    pipe_skid_stage #(
        .DATA_W    (DW),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] got[$];
    bit            m_rdy;
    int            m_stall;
    int            pass_cnt;
    int            total_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("occupancy", 32'(occupancy), mq.size());
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), m_stall);
`endif
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d,
                         input bit r, input bit f);
        bit inf;
        bit outf;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        inf  = v && m_rdy && !f;
        outf = (mq.size() > 0) && r;
        if (v && !m_rdy && !f && m_stall < (1 << CW) - 1) m_stall++;
        @(posedge clk);
        if (outf) got.push_back(mq.pop_front());
        if (f) mq.delete();
        else if (inf) mq.push_back(d);
        m_rdy = (mq.size() < 2);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 20'hFFFFF;
        repeat (n) @(posedge clk);
        mq.delete();
        m_rdy   = 1'b0;
        m_stall = 0;
        @(negedge clk);
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_all();
        chk("rst_out_data", 32'(out_data), 32'(RV));
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        m_rdy     = 1'b0;
        m_stall   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(negedge clk);

        // 1: reset then full-rate stream
        do_reset(2);
        got.delete();
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 20'(i), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("stream_cnt", got.size(), 5);
        for (int i = 0; i < got.size(); i++)
            chk("stream_data", 32'(got[i]), i + 1);

        // 2: backpressure absorbs two beats, third held upstream
        got.delete();
        cycle(1'b1, 20'hAAAAA, 1'b0, 1'b0);
        cycle(1'b1, 20'h55555, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 20'h12345, 1'b0, 1'b0);
        chk("bp_occ", 32'(occupancy), 2);
        chk("bp_ready", 32'(in_ready), 0);
        cycle(1'b1, 20'h12345, 1'b1, 1'b0);
        cycle(1'b1, 20'h12345, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_cnt", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_d0", 32'(got[0]), 32'h0AAAAA);
            chk("bp_d1", 32'(got[1]), 32'h055555);
            chk("bp_d2", 32'(got[2]), 32'h012345);
        end

        // 3: flush while full drops everything incl. same-cycle input
        got.delete();
        cycle(1'b1, 20'h11111, 1'b0, 1'b0);
        cycle(1'b1, 20'h22222, 1'b0, 1'b0);
        cycle(1'b1, 20'hFFFFF, 1'b0, 1'b1);
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_occ", 32'(occupancy), 0);
        chk("fl_ready", 32'(in_ready), 1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("fl_none_out", got.size(), 0);

        // 4: flush with same-cycle transfer in BUSY
        got.delete();
        cycle(1'b1, 20'h00042, 1'b0, 1'b0);
        chk("fo_data", 32'(out_data), 32'h42);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("fo_cnt", got.size(), 1);
        if (got.size() == 1) chk("fo_got", 32'(got[0]), 32'h42);
        chk("fo_occ", 32'(occupancy), 0);

        // 5: reset while full
        cycle(1'b1, 20'h000A1, 1'b0, 1'b0);
        cycle(1'b1, 20'h000B2, 1'b0, 1'b0);
        chk("rf_occ", 32'(occupancy), 2);
        do_reset(1);
        chk("rf_valid", 32'(out_valid), 0);
        chk("rf_ready", 32'(in_ready), 0);

        // random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, 20'($urandom),
                  ($urandom % 3) != 0, ($urandom % 20) == 0);
        end

`ifdef PIPE_STALL_CNT_EN
        // 6: stall counter saturates, survives flush, cleared by reset
        do_reset(1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 20'h1, 1'b0, 1'b0);
        cycle(1'b1, 20'h2, 1'b0, 1'b0);
        repeat (20) cycle(1'b1, 20'h3, 1'b0, 1'b0);
        chk("sc_sat", 32'(stall_cnt), 15);
        cycle(1'b1, 20'h3, 1'b0, 1'b1);
        chk("sc_flush", 32'(stall_cnt), 15);
        do_reset(1);
        chk("sc_rst", 32'(stall_cnt), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
